// File: rtl/voice_mixer.sv
`default_nettype none
// ============================================================================
// Module   : voice_mixer
// Purpose  : Collects one sample from every busy note player after each frame
//            strobe, sums the voices serially on a single adder, attenuates
//            the sum by an arithmetic right shift, range-limits it and
//            presents it to the codec conditioner with a one-cycle ready pulse.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   NUM_VOICES  : number of voice inputs (1..4)
//   ATTEN_SHIFT : arithmetic right shift applied to the sum (0..3)
//   TIMEOUT     : maximum number of cycles spent collecting (2..255)
// Ports
//   clk                  in  : system clock
//   reset                in  : asynchronous reset, active low
//   generate_next_sample in  : one-cycle frame strobe, opens a collection window
//   voice_active         in  : per-voice busy flag, bit i is voice i
//   sample_in            in  : packed signed samples, voice i at [16i+15:16i]
//   sample_ready         in  : per-voice one-cycle valid pulse for sample_in
//   mix_out              out : signed mixed sample, holds between updates
//   mix_ready            out : one-cycle pulse when mix_out updates
//   clipped              out : with mix_ready, the result was saturated
//   late                 out : with mix_ready, the window closed on timeout
// Build option
//   VOICE_MIXER_SATURATE_EN : when defined the shifted sum saturates to the
//                             16-bit signed range and flags clipped; otherwise
//                             it wraps (low 16 bits) and clipped stays 0.
// ============================================================================
module voice_mixer #(
  parameter int NUM_VOICES  = 3,
  parameter int ATTEN_SHIFT = 1,
  parameter int TIMEOUT     = 64
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      generate_next_sample,
  input  logic [NUM_VOICES-1:0]     voice_active,
  input  logic [16*NUM_VOICES-1:0]  sample_in,
  input  logic [NUM_VOICES-1:0]     sample_ready,
  output logic [15:0]               mix_out,
  output logic                      mix_ready,
  output logic                      clipped,
  output logic                      late
);

  localparam int IDX_W = 2;
  localparam int CNT_W = 8;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_ACCUM   = 2'd2,
    S_OUTPUT  = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [15:0]            hold_q [NUM_VOICES];
  logic [15:0]            hold_d [NUM_VOICES];
  logic [NUM_VOICES-1:0]  expect_q, expect_d;
  logic [NUM_VOICES-1:0]  got_q, got_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic signed [17:0]     acc_q, acc_d;
  logic                   late_flag_q, late_flag_d;
  logic [15:0]            mix_out_q, mix_out_d;
  logic                   mix_ready_q, mix_ready_d;
  logic                   clipped_q, clipped_d;
  logic                   late_q, late_d;

  logic [NUM_VOICES-1:0]  got_next;
  logic signed [17:0]     term;
  logic signed [17:0]     acc_sum;
  logic [15:0]            result;
  logic                   result_clip;

  // Hold registers capture a voice sample whenever it is offered, in any
  // state; only the got mask decides whether it takes part in a mix.
  always_comb begin
    for (int i = 0; i < NUM_VOICES; i++) begin
      hold_d[i] = sample_ready[i] ? sample_in[16*i +: 16] : hold_q[i];
    end
  end

  // Includes pulses arriving this cycle so the completing sample moves the
  // machine to ACCUM on the very next edge.
  assign got_next = got_q | sample_ready;

  // Operand for the serial adder: the indexed voice, or zero when that voice
  // was not expected or never delivered inside the window.
  always_comb begin
    term = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      if ((idx_q == IDX_W'(i)) && expect_q[i] && got_q[i]) begin
        term = {{2{hold_q[i][15]}}, hold_q[i]};
      end
    end
  end

  assign acc_sum = acc_q + term;

`ifdef VOICE_MIXER_SATURATE_EN
  localparam logic signed [17:0] SAT_MAX = 18'sd32767;
  localparam logic signed [17:0] SAT_MIN = -18'sd32768;

  logic signed [17:0] shifted;

  always_comb begin
    shifted     = acc_sum >>> ATTEN_SHIFT;
    result      = shifted[15:0];
    result_clip = 1'b0;
    if (shifted > SAT_MAX) begin
      result      = 16'h7FFF;
      result_clip = 1'b1;
    end else if (shifted < SAT_MIN) begin
      result      = 16'h8000;
      result_clip = 1'b1;
    end
  end
`else
  always_comb begin
    result      = 16'(acc_sum >>> ATTEN_SHIFT);
    result_clip = 1'b0;
  end
`endif

  always_comb begin
    state_d     = state_q;
    expect_d    = expect_q;
    got_d       = got_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    acc_d       = acc_q;
    late_flag_d = late_flag_q;
    mix_out_d   = mix_out_q;
    mix_ready_d = 1'b0;
    clipped_d   = 1'b0;
    late_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (generate_next_sample) begin
          expect_d    = voice_active;
          got_d       = '0;
          cnt_d       = '0;
          late_flag_d = 1'b0;
          state_d     = S_COLLECT;
        end
      end

      S_COLLECT: begin
        got_d = got_next;
        // Completion wins over timeout when both happen in the same cycle.
        if ((got_next & expect_q) == expect_q) begin
          idx_d   = '0;
          acc_d   = '0;
          state_d = S_ACCUM;
        end else if (cnt_q == CNT_LAST) begin
          idx_d       = '0;
          acc_d       = '0;
          late_flag_d = 1'b1;
          state_d     = S_ACCUM;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_ACCUM: begin
        acc_d = acc_sum;
        idx_d = idx_q + IDX_W'(1);
        if (idx_q == LAST_IDX) begin
          // The final partial sum is shifted and limited on the way into
          // mix_out, so the status flags line up with the new value.
          mix_out_d   = result;
          mix_ready_d = 1'b1;
          clipped_d   = result_clip;
          late_d      = late_flag_q;
          state_d     = S_OUTPUT;
        end
      end

      S_OUTPUT: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      for (int i = 0; i < NUM_VOICES; i++) begin
        hold_q[i] <= '0;
      end
      expect_q    <= '0;
      got_q       <= '0;
      cnt_q       <= '0;
      idx_q       <= '0;
      acc_q       <= '0;
      late_flag_q <= 1'b0;
      mix_out_q   <= '0;
      mix_ready_q <= 1'b0;
      clipped_q   <= 1'b0;
      late_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      for (int i = 0; i < NUM_VOICES; i++) begin
        hold_q[i] <= hold_d[i];
      end
      expect_q    <= expect_d;
      got_q       <= got_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      acc_q       <= acc_d;
      late_flag_q <= late_flag_d;
      mix_out_q   <= mix_out_d;
      mix_ready_q <= mix_ready_d;
      clipped_q   <= clipped_d;
      late_q      <= late_d;
    end
  end

  assign mix_out   = mix_out_q;
  assign mix_ready = mix_ready_q;
  assign clipped   = clipped_q;
  assign late      = late_q;

endmodule
`default_nettype wire

// File: tb/tb_voice_mixer.sv
`default_nettype none
// ============================================================================
// Module   : tb_voice_mixer
// Purpose  : Self-checking bench for voice_mixer (NUM_VOICES=3, ATTEN_SHIFT=1,
//            TIMEOUT=64). Directed frame table plus random frames checked
//            against a frame-level reference model, and reset sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_voice_mixer;

  localparam int NV  = 3;
  localparam int ATT = 1;
  localparam int TO  = 64;

  logic              clk   = 1'b0;
  logic              reset = 1'b0;
  logic              gns   = 1'b0;
  logic [NV-1:0]     va    = '0;
  logic [16*NV-1:0]  si    = '0;
  logic [NV-1:0]     sr    = '0;
  logic [15:0]       mix_out;
  logic              mix_ready;
  logic              clipped;
  logic              late;

  int n_tests = 0;
  int n_fail  = 0;

  voice_mixer #(
    .NUM_VOICES (NV),
    .ATTEN_SHIFT(ATT),
    .TIMEOUT    (TO)
  ) dut (
    .clk                 (clk),
    .reset               (reset),
    .generate_next_sample(gns),
    .voice_active        (va),
    .sample_in           (si),
    .sample_ready        (sr),
    .mix_out             (mix_out),
    .mix_ready           (mix_ready),
    .clipped             (clipped),
    .late                (late)
  );

  always #5 clk = ~clk;

  // One frame: strobe at cycle 0, voice i pulses pval[i] at cycle pcyc[i]
  // (0 = no pulse), optional second strobe at cycle strobe2 (0 = none).
  typedef struct {
    logic [NV-1:0]        active;
    logic [NV-1:0][7:0]   pcyc;
    logic [NV-1:0][15:0]  pval;
    int                   strobe2;
    logic [15:0]          exp_mix;
    int                   exp_ready;
    logic                 exp_clip;
    logic                 exp_late;
  } frame_t;

  frame_t tbl [8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, req);
    end
  endtask

  function automatic frame_t mk(input logic [NV-1:0] act,
                                input int c0, input int c1, input int c2,
                                input int v0, input int v1, input int v2,
                                input int s2, input int emix, input int erdy,
                                input logic eclip, input logic elate);
    frame_t f;
    f.active    = act;
    f.pcyc[0]   = 8'(c0);
    f.pcyc[1]   = 8'(c1);
    f.pcyc[2]   = 8'(c2);
    f.pval[0]   = 16'(v0);
    f.pval[1]   = 16'(v1);
    f.pval[2]   = 16'(v2);
    f.strobe2   = s2;
    f.exp_mix   = 16'(emix);
    f.exp_ready = erdy;
    f.exp_clip  = eclip;
    f.exp_late  = elate;
    return f;
  endfunction

  // Frame-level reference: the window closes at the latest first pulse of the
  // expected voices, or at TIMEOUT when one of them never arrives.
  function automatic frame_t model(input frame_t f);
    frame_t r;
    int     t;
    bit     complete;
    int     sum;
    int     sh;
    r        = f;
    t        = 1;
    complete = 1'b1;
    for (int i = 0; i < NV; i++) begin
      if (f.active[i]) begin
        if (f.pcyc[i] >= 1 && int'(f.pcyc[i]) <= TO) begin
          if (int'(f.pcyc[i]) > t) t = int'(f.pcyc[i]);
        end else begin
          complete = 1'b0;
        end
      end
    end
    if (!complete) t = TO;
    sum = 0;
    for (int i = 0; i < NV; i++) begin
      if (f.active[i] && f.pcyc[i] >= 1 && int'(f.pcyc[i]) <= t)
        sum += int'($signed(f.pval[i]));
    end
    sh = sum >>> ATT;
`ifdef VOICE_MIXER_SATURATE_EN
    if (sh > 32767) begin
      r.exp_mix = 16'h7FFF; r.exp_clip = 1'b1;
    end else if (sh < -32768) begin
      r.exp_mix = 16'h8000; r.exp_clip = 1'b1;
    end else begin
      r.exp_mix = 16'(sh);  r.exp_clip = 1'b0;
    end
`else
    r.exp_mix  = 16'(sh);
    r.exp_clip = 1'b0;
`endif
    r.exp_ready = t + NV + 1;
    r.exp_late  = !complete;
    return r;
  endfunction

  // Idle cycles with random voice pulses: mix_out must hold, no mix_ready.
  task automatic idle_hold(input int n);
    logic [15:0] ref_mix;
    bit          bad;
    ref_mix = mix_out;
    bad     = 1'b0;
    for (int c = 0; c < n; c++) begin
      if (mix_ready || mix_out !== ref_mix) bad = 1'b1;
      gns = 1'b0;
      va  = NV'($urandom);
      sr  = (c == 0) ? '1 : NV'($urandom);
      for (int i = 0; i < NV; i++) si[16*i +: 16] = 16'($urandom);
      tick();
    end
    sr = '0;
    check("idle_hold", {31'b0, bad}, 32'd0);
  endtask

  task automatic run_frame(input string name, input frame_t f);
    int          rdy_cnt;
    int          rdy_at;
    logic [15:0] got_mix;
    logic        got_clip;
    logic        got_late;
    bit          stable;
    rdy_cnt  = 0;
    rdy_at   = -1;
    got_mix  = '0;
    got_clip = 1'b0;
    got_late = 1'b0;
    stable   = 1'b1;
    for (int c = 0; c <= f.exp_ready + 3; c++) begin
      if (mix_ready) begin
        rdy_cnt++;
        if (rdy_at < 0) begin
          rdy_at   = c;
          got_mix  = mix_out;
          got_clip = clipped;
          got_late = late;
        end
      end else if (rdy_at >= 0 && mix_out !== got_mix) begin
        stable = 1'b0;
      end
      gns = (c == 0) || (f.strobe2 != 0 && c == f.strobe2);
      va  = f.active;
      sr  = '0;
      for (int i = 0; i < NV; i++) begin
        if (f.pcyc[i] != 0 && int'(f.pcyc[i]) == c) begin
          sr[i]          = 1'b1;
          si[16*i +: 16] = f.pval[i];
        end
      end
      tick();
    end
    gns = 1'b0;
    sr  = '0;
    check({name, " ready_count"}, rdy_cnt, 32'd1);
    check({name, " ready_cycle"}, rdy_at, f.exp_ready);
    check({name, " mix_out"}, {16'b0, got_mix}, {16'b0, f.exp_mix});
    check({name, " clipped"}, {31'b0, got_clip}, {31'b0, f.exp_clip});
    check({name, " late"}, {31'b0, got_late}, {31'b0, f.exp_late});
    check({name, " hold"}, {31'b0, stable}, 32'd1);
  endtask

  initial begin
    frame_t f;
    int     rcnt;
    bit     bad;

    tbl[0] = mk(3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 5, 1'b0, 1'b0);
    tbl[1] = mk(3'b111, 3, 7, 12, 1000, 2000, -500, 0, 1250, 16, 1'b0, 1'b0);
`ifdef VOICE_MIXER_SATURATE_EN
    tbl[2] = mk(3'b111, 2, 2, 2, 30000, 30000, 30000, 0, 32'h7FFF, 6, 1'b1, 1'b0);
    tbl[3] = mk(3'b111, 1, 4, 2, -30000, -30000, -30000, 0, 32'h8000, 8, 1'b1, 1'b0);
`else
    tbl[2] = mk(3'b111, 2, 2, 2, 30000, 30000, 30000, 0, 32'hAFC8, 6, 1'b0, 1'b0);
    tbl[3] = mk(3'b111, 1, 4, 2, -30000, -30000, -30000, 0, 32'h5038, 8, 1'b0, 1'b0);
`endif
    tbl[4] = mk(3'b111, 5, 0, 0, 4000, 0, 0, 0, 2000, 68, 1'b0, 1'b1);
    tbl[5] = mk(3'b010, 2, 3, 4, 5000, 600, 5000, 2, 300, 7, 1'b0, 1'b0);
    tbl[6] = mk(3'b101, 1, 0, 64, 100, 0, 300, 0, 200, 68, 1'b0, 1'b0);
    tbl[7] = mk(3'b010, 0, 0, 0, 0, 0, 0, 0, 0, 68, 1'b0, 1'b1);

    // Reset held with inputs toggling.
    reset = 1'b0;
    bad   = 1'b0;
    for (int c = 0; c < 8; c++) begin
      gns = 1'($urandom);
      va  = NV'($urandom);
      sr  = NV'($urandom);
      for (int i = 0; i < NV; i++) si[16*i +: 16] = 16'($urandom);
      tick();
      if (mix_out !== 16'h0 || mix_ready !== 1'b0 || clipped !== 1'b0 || late !== 1'b0)
        bad = 1'b1;
    end
    check("reset_outputs", {31'b0, bad}, 32'd0);
    gns   = 1'b0;
    sr    = '0;
    va    = '0;
    reset = 1'b1;
    tick();
    check("post_reset mix_out", {16'b0, mix_out}, 32'd0);

    // Directed frame table.
    for (int k = 0; k < 8; k++) begin
      if (k != 0) idle_hold(3);
      run_frame($sformatf("tbl%0d", k), tbl[k]);
    end

    // Random frames against the reference model.
    for (int k = 0; k < 40; k++) begin
      f.active = NV'($urandom);
      for (int i = 0; i < NV; i++) begin
        rcnt = int'($urandom_range(0, 9));
        if (rcnt == 0)      f.pcyc[i] = 8'd0;
        else if (rcnt == 1) f.pcyc[i] = 8'($urandom_range(60, 70));
        else                f.pcyc[i] = 8'($urandom_range(1, 20));
        f.pval[i] = 16'($urandom);
      end
      f.strobe2 = 0;
      f = model(f);
      if ($urandom_range(0, 1) == 1)
        f.strobe2 = int'($urandom_range(1, f.exp_ready - NV - 1));
      idle_hold(2);
      run_frame($sformatf("rnd%0d", k), f);
    end

    // Reset in the second ACCUM cycle after a frame that left mix_out nonzero.
    idle_hold(2);
    run_frame("pre_reset", tbl[1]);
    gns = 1'b1;
    va  = 3'b000;
    sr  = '0;
    tick();
    gns = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    #1;
    check("midreset mix_out", {16'b0, mix_out}, 32'd0);
    check("midreset mix_ready", {31'b0, mix_ready}, 32'd0);
    #2;
    reset = 1'b1;
    rcnt  = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (mix_ready) rcnt++;
    end
    check("midreset no_ready", rcnt, 32'd0);
    run_frame("after_reset", tbl[0]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
